// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a single-port byte memory: fixed data priority with a fetch starvation guard.
// Define ARB_STATS_EN to add the stat_conflicts / stat_starve_wins / stat_errors counters.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef ARB_STATS_EN
  output logic [31:0]       stat_conflicts,
  output logic [31:0]       stat_starve_wins,
  output logic [15:0]       stat_errors,
`endif
  input  logic [31:0]       mem_data
);

  localparam int CW = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  typedef struct packed {
    owner_e owner;
    logic   err;
    logic   we;
  } iss_t;

  logic [CW-1:0] starve_cnt;
  logic          starve_hit;
  logic          d_bad;
  iss_t          iss;

  assign starve_hit = (starve_cnt == CW'(STARVE_MAX));

  // Data wins a conflict unless fetch has already lost STARVE_MAX cycles in a row.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (d_req && !(if_req && starve_hit)) d_gnt  = 1'b1;
    else if (if_req)                      if_gnt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 starve_cnt <= '0;
    else if (if_req && !if_gnt) starve_cnt <= starve_hit ? starve_cnt : starve_cnt + CW'(1);
    else                        starve_cnt <= '0;
  end

  // Misalignment and illegal size/sign encodings; stores have no unsigned forms.
  always_comb begin
    d_bad = 1'b0;
    case (d_funct3)
      3'b000:         d_bad = 1'b0;
      3'b001:         d_bad = d_addr[0];
      3'b010:         d_bad = |d_addr[1:0];
      3'b100:         d_bad = d_we;
      3'b101:         d_bad = d_we | d_addr[0];
      default:        d_bad = 1'b1;
    endcase
  end

  // Issue stage: drives the memory port for exactly one cycle per grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss        <= '{owner: OWN_NONE, err: 1'b0, we: 1'b0};
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_funct3 <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      iss       <= '{owner: OWN_NONE, err: 1'b0, we: 1'b0};
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (if_gnt) begin
        iss.owner  <= OWN_IF;
        mem_read   <= 1'b1;
        mem_funct3 <= 3'b010;
        mem_addr   <= if_addr;
      end else if (d_gnt) begin
        iss        <= '{owner: OWN_D, err: d_bad, we: d_we};
        mem_funct3 <= d_funct3;
        mem_addr   <= d_addr;
        if (!d_bad) begin
          if (d_we) begin
            mem_write <= 1'b1;
            mem_wdata <= d_wdata;
          end else begin
            mem_read  <= 1'b1;
          end
        end
      end
    end
  end

  // Response stage: capture mem_data at the edge that closes the issue cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      case (iss.owner)
        OWN_IF: begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_data;
        end
        OWN_D: begin
          d_rvalid <= 1'b1;
          d_err    <= iss.err;
          d_rdata  <= (iss.err || iss.we) ? 32'h0 : mem_data;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts   <= '0;
      stat_starve_wins <= '0;
      stat_errors      <= '0;
    end else begin
      if (if_req && d_req)               stat_conflicts   <= stat_conflicts + 32'd1;
      if (if_req && d_req && starve_hit) stat_starve_wins <= stat_starve_wins + 32'd1;
      if (iss.owner == OWN_D && iss.err) stat_errors      <= stat_errors + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors, expected responses queued at grant time.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_data;
`ifdef ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_starve_wins;
  logic [15:0] stat_errors;
`endif

  mem_port_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_starve_wins(stat_starve_wins),
    .stat_errors(stat_errors),
`endif
    .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory model; sizing/sign handled here like the real memory.
  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  logic [31:0] mw;

  always_comb begin
    ma       = mem_addr[7:0];
    mw       = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    mem_data = mw;
    case (mem_funct3)
      3'b000: mem_data = {{24{mw[7]}}, mw[7:0]};
      3'b001: mem_data = {{16{mw[15]}}, mw[15:0]};
      3'b100: mem_data = {24'h0, mw[7:0]};
      3'b101: mem_data = {16'h0, mw[15:0]};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) mem[ma + 8'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[ma + 8'd2] <= mem_wdata[23:16];
        mem[ma + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } dexp_t;

  logic [31:0] if_q [$];
  dexp_t       d_q  [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one data request for a cycle, check its grant and queue the expected response.
  task automatic issue_d(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    dexp_t e;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    @(negedge clk);
    chk("d_gnt", 32'(d_gnt), 32'd1);
    chk("if_gnt_off", 32'(if_gnt), 32'd0);
    e.rdata = exp_rd;
    e.err   = exp_err;
    d_q.push_back(e);
    tick();
    d_req = 1'b0; d_we = 1'b0;
  endtask

  // Monitor: every response must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL if_unexpected: got rvalid with rdata %h expected none", if_rdata);
        end else begin
          chk("if_rdata", if_rdata, if_q.pop_front());
        end
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL d_unexpected: got rvalid with rdata %h expected none", d_rdata);
        end else begin
          dexp_t e;
          e = d_q.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_err", 32'(d_err), 32'(e.err));
        end
      end
    end
  end

  logic any_out;
  assign any_out = |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
                     mem_read, mem_write, mem_funct3, mem_addr, mem_wdata};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(any_out), 32'd0);
    tick();
    rst_n = 1'b1;

    // Fetch only: grant now, issue next cycle, response the cycle after.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("if_gnt", 32'(if_gnt), 32'd1);
    chk("d_gnt_idle", 32'(d_gnt), 32'd0);
    if_q.push_back(32'hDEADBEEF);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("if_mem_read", 32'(mem_read), 32'd1);
    chk("if_mem_funct3", 32'(mem_funct3), 32'd2);
    chk("if_mem_addr", mem_addr, 32'h10);
    tick();
    @(negedge clk);
    chk("if_rvalid_lat", 32'(if_rvalid), 32'd1);
    tick();

    // sw 0x12345678 @0x20, then lbu @0x21.
    issue_d(1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0);
    @(negedge clk);
    chk("sw_mem_write", 32'({mem_write, mem_read}), 32'd2);
    chk("sw_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    issue_d(1'b0, 3'b100, 32'h21, 32'h0, 32'h56, 1'b0);
    @(negedge clk);
    chk("lbu_mem_read", 32'({mem_write, mem_read}), 32'd1);
    tick();

    // Rejected accesses: lw @0x22, sh @0x21, store with funct3 100.
    issue_d(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_lw_port_idle", 32'({mem_write, mem_read}), 32'd0);
    tick();
    issue_d(1'b1, 3'b001, 32'h21, 32'h0000AAAA, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_sh_port_idle", 32'({mem_write, mem_read}), 32'd0);
    tick();
    issue_d(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
    @(negedge clk);
    chk("ill_st_port_idle", 32'({mem_write, mem_read}), 32'd0);
    repeat (3) tick();
    chk("mem_unchanged", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h12345678);

    // Conflict: D wins four times, then the starving fetch wins; repeats.
    for (int k = 0; k < 10; k++) begin
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h20;
      @(negedge clk);
      if (k == 4 || k == 9) begin
        chk("conflict_gnt", 32'({if_gnt, d_gnt}), 32'd2);
        if_q.push_back(32'hDEADBEEF);
      end else begin
        dexp_t e;
        chk("conflict_gnt", 32'({if_gnt, d_gnt}), 32'd1);
        e.rdata = 32'h12345678;
        e.err   = 1'b0;
        d_q.push_back(e);
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflicts", stat_conflicts, 32'd10);
    chk("stat_starve_wins", stat_starve_wins, 32'd2);
    chk("stat_errors", 32'(stat_errors), 32'd3);
`endif
    repeat (3) tick();

    // Reset during the issue cycle of a load: no response may follow.
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10;
    @(negedge clk);
    chk("rst_load_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 32'(any_out), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_after_outs", 32'(any_out), 32'd0);
`ifdef ARB_STATS_EN
    chk("stat_cleared", stat_conflicts | stat_starve_wins | 32'(stat_errors), 32'd0);
`endif
    repeat (2) tick();

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
